caesar_ctxt_collector: RTL and testbench
========================================

# caesar_ctxt_collector

Receiving end of the `caesar_cipher` output interface. It samples the per-cycle result of the cipher (`ctxt_char`, `ctx_ready`, error flags) and normalises it into an ordered byte stream. The byte stream is buffered in a FIFO and drained downstream with a valid/ready handshake. It also keeps per-message statistics and a sticky overflow state, so file-level encrypt/decrypt runs can be streamed without a testbench-side queue.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `CNT_W`, 16: width of the statistics counters.
- `clk` input 1: clock; everything is sampled on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ctx_ready` input 1: from the cipher; `ctxt_char` is valid this cycle.
- `ctxt_char` input 8: cipher output byte.
- `err_invalid_ptxt_char` input 1: from the cipher; the input byte was not a letter.
- `err_invalid_key_shift_num` input 1: from the cipher; the key is invalid.
- `clear` input 1: synchronous; zeroes the counters, empties the FIFO and leaves OVERFLOW.
- `out_valid` output 1: `out_data` is valid.
- `out_data` output 8: head of the FIFO.
- `out_ready` input 1: downstream accepts the byte.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `letter_cnt` output CNT_W: number of ciphered letters accepted.
- `subst_cnt` output CNT_W: number of 0x20 substitutions accepted.
- `keyerr_cnt` output CNT_W: number of cycles with a key error.
- `fill` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Result classification**, evaluated each cycle in this priority order:
  - `err_invalid_key_shift_num`=1: no push; `keyerr_cnt`++ (saturating).
  - Else `ctx_ready`=1: push `ctxt_char`; `letter_cnt`++.
  - Else `err_invalid_ptxt_char`=1: push SPACE_CHAR (0x20); `subst_cnt`++.
  - Else: idle cycle, no action.
- **FSM states:**
  - IDLE: FIFO empty, no push yet.
  - STREAM: at least one byte written since the last reset or clear.
  - OVERFLOW: entered on a push while full and not popping in the same cycle.
- **FSM transitions:**
  - IDLE to STREAM on the first push.
  - STREAM to IDLE when the FIFO empties and no push is pending.
  - Any state to OVERFLOW on a drop.
  - OVERFLOW to IDLE only on `clear`.
- **OVERFLOW behaviour:**
  - Pushes continue to be accepted when space exists.
  - `overflow`=1 for as long as the state is OVERFLOW.
  - The dropped byte is not counted.
- **Counters:** saturate at all-ones and never wrap. They are incremented only for bytes actually pushed; key-error cycles are the exception and are always counted.
- **`clear`:** has priority over every push and pop in the same cycle.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0x00.
  - `overflow`=0.
  - All counters 0, `fill`=0.
  - State IDLE.
- **Latency:** a byte pushed at edge N appears on `out_data` with `out_valid`=1 after edge N if the FIFO was empty. There is no combinational path from the cipher inputs to `out_*`.
- **Handshake:** a pop happens on an edge where `out_valid`&&`out_ready`. `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- **Full FIFO:** a simultaneous push and pop when full is legal. It is not an overflow and `fill` stays at DEPTH.
- **Empty FIFO:** a pop when empty is ignored. A simultaneous push is legal and sets `fill`=1.
- **Pointers:** wrap modulo DEPTH. Full and empty are distinguished by an extra MSB on each pointer.
- **Mid-operation reset:** asynchronous; all FIFO contents are lost and outputs return to their reset values immediately.

## Structure
- **`caesar_pkg`:**
  - Constants SPACE_CHAR (0x20), UPPERCASE_A/Z, LOWERCASE_A/Z.
  - Typedef `collector_state_t` {IDLE, STREAM, OVERFLOW}.
  - Typedef `char_t` (logic [7:0]).
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH; provides push, pop, full, empty, count and registered head output.
- **Top-level contents:** classification logic, FSM and counters.

## Test plan
- Letters "A".."Z": pulse `ctx_ready` with `ctxt_char`="F".."Z","A".."E" for 26 cycles, `out_ready`=1 → `out_data` sequence matches in order, `letter_cnt`=26, `subst_cnt`=0.
- Mixed input: `ctx_ready`("h"), `err_invalid_ptxt_char`, `ctx_ready`("i") → out bytes 0x68, 0x20, 0x69; `subst_cnt`=1.
- Key error: `err_invalid_key_shift_num`=1 together with `ctx_ready`=1 for 5 cycles → nothing pushed, `keyerr_cnt`=5, `fill`=0, state IDLE.
- Overflow at DEPTH=16: `out_ready`=0, 17 pushes → `fill`=16, `overflow`=1, `letter_cnt`=16. Then `out_ready`=1 → the first 16 bytes drain in order and `overflow` stays 1 until `clear`.
- Full with simultaneous push and pop: at `fill`=16 with `out_ready`=1 → `fill`=16, `overflow`=0, order preserved.
- Reset asserted at `fill`=7 → `out_valid`=0, counters 0, state IDLE at once. The next push after reset is the first byte out.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared types and character constants for the Caesar cipher datapath.
package caesar_pkg;

  typedef logic [7:0] char_t;

  localparam char_t SPACE_CHAR  = 8'h20;
  localparam char_t UPPERCASE_A = 8'h41;
  localparam char_t UPPERCASE_Z = 8'h5A;
  localparam char_t LOWERCASE_A = 8'h61;
  localparam char_t LOWERCASE_Z = 8'h7A;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StOverflow
  } collector_state_t;

endpackage

// File: rtl/caesar_ctxt_collector_if.sv
// Cipher-result inputs plus the downstream valid/ready byte stream.
interface caesar_ctxt_collector_if;
  import caesar_pkg::*;

  logic  ctx_ready;
  char_t ctxt_char;
  logic  err_invalid_ptxt_char;
  logic  err_invalid_key_shift_num;
  logic  out_valid;
  char_t out_data;
  logic  out_ready;

  // Cipher and downstream consumer side
  modport master (
    output ctx_ready, ctxt_char, err_invalid_ptxt_char, err_invalid_key_shift_num, out_ready,
    input  out_valid, out_data
  );

  // Collector side
  modport slave (
    input  ctx_ready, ctxt_char, err_invalid_ptxt_char, err_invalid_key_shift_num, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered head-of-queue output.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [Width-1:0]         head_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] head_q, head_d;
  logic             push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = head_q;

  // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle
  assign pop_en  = pop_i & ~empty_o & ~clr_i;
  assign push_en = push_i & (~full_o | pop_en) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AddrW + 1)'(push_en);
    rd_ptr_d = rd_ptr_q + (AddrW + 1)'(pop_en);
    head_d   = mem_q[rd_ptr_d[AddrW-1:0]];
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      head_d   = '0;
    end else if (push_en && (wr_ptr_q[AddrW-1:0] == rd_ptr_d[AddrW-1:0])) begin
      // The new head is the byte being written this cycle
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/caesar_ctxt_collector.sv
// Classifies per-cycle cipher results into a buffered byte stream with statistics.
module caesar_ctxt_collector
  import caesar_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned CntW  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  caesar_ctxt_collector_if.slave  ctxt_if,
  input  logic                    clear_i,
  output logic                    overflow_o,
  output logic [CntW-1:0]         letter_cnt_o,
  output logic [CntW-1:0]         subst_cnt_o,
  output logic [CntW-1:0]         keyerr_cnt_o,
  output logic [$clog2(Depth):0]  fill_o
);

  collector_state_t state_q, state_d;
  logic [CntW-1:0]  letter_q, letter_d, subst_q, subst_d, keyerr_q, keyerr_d;
  logic             key_err, push_req, push_acc, drop, pop;
  logic             fifo_full, fifo_empty;
  char_t            push_data;

  assign key_err   = ctxt_if.err_invalid_key_shift_num;
  assign push_req  = ~key_err & (ctxt_if.ctx_ready | ctxt_if.err_invalid_ptxt_char);
  assign push_data = ctxt_if.ctx_ready ? ctxt_if.ctxt_char : SPACE_CHAR;
  assign pop       = ~fifo_empty & ctxt_if.out_ready;
  assign drop      = push_req & fifo_full & ~pop & ~clear_i;
  assign push_acc  = push_req & ~drop & ~clear_i;

  sync_fifo #(
    .Width (8),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_o),
    .head_o  (ctxt_if.out_data)
  );

  assign ctxt_if.out_valid = ~fifo_empty;
  assign overflow_o        = (state_q == StOverflow);
  assign letter_cnt_o      = letter_q;
  assign subst_cnt_o       = subst_q;
  assign keyerr_cnt_o      = keyerr_q;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (drop)          state_d = StOverflow;
          else if (push_acc) state_d = StStream;
        end
        StStream: begin
          if (drop)                        state_d = StOverflow;
          else if (fifo_empty && !push_req) state_d = StIdle;
        end
        StOverflow: state_d = StOverflow;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Counters saturate at all-ones; key errors count regardless of FIFO state
  always_comb begin
    letter_d = letter_q;
    subst_d  = subst_q;
    keyerr_d = keyerr_q;
    if (clear_i) begin
      letter_d = '0;
      subst_d  = '0;
      keyerr_d = '0;
    end else begin
      if (key_err && !(&keyerr_q)) keyerr_d = keyerr_q + CntW'(1);
      if (push_acc && ctxt_if.ctx_ready && !(&letter_q)) letter_d = letter_q + CntW'(1);
      if (push_acc && !ctxt_if.ctx_ready && !(&subst_q)) subst_d = subst_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      letter_q <= '0;
      subst_q  <= '0;
      keyerr_q <= '0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_d;
      subst_q  <= subst_d;
      keyerr_q <= keyerr_d;
    end
  end

endmodule

// File: tb/tb_caesar_ctxt_collector.sv
// Directed bench for caesar_ctxt_collector with immediate-assertion checks.
module tb_caesar_ctxt_collector;
  import caesar_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        overflow;
  logic [15:0] letter_cnt, subst_cnt, keyerr_cnt;
  logic [4:0]  fill;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  caesar_ctxt_collector_if bus ();

  caesar_ctxt_collector #(
    .Depth (16),
    .CntW  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ctxt_if      (bus),
    .clear_i      (clear),
    .overflow_o   (overflow),
    .letter_cnt_o (letter_cnt),
    .subst_cnt_o  (subst_cnt),
    .keyerr_cnt_o (keyerr_cnt),
    .fill_o       (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [7:0] ch, input logic perr, input logic kerr);
    bus.ctx_ready                 = rdy;
    bus.ctxt_char                 = ch;
    bus.err_invalid_ptxt_char     = perr;
    bus.err_invalid_key_shift_num = kerr;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.out_data}, 32'h00);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_letter", {16'd0, letter_cnt}, 32'd0);
    chk("rst_fill", {27'd0, fill}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Shifted alphabet F..Z,A..E streams straight through
    bus.out_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      drive(1'b1, 8'(8'h41 + ((i + 5) % 26)), 1'b0, 1'b0);
      step();
      chk("alpha_data", {24'd0, bus.out_data}, 32'(8'h41 + ((i + 5) % 26)));
      chk("alpha_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("alpha_drained", {31'd0, bus.out_valid}, 32'd0);
    chk("alpha_letter", {16'd0, letter_cnt}, 32'd26);
    chk("alpha_subst", {16'd0, subst_cnt}, 32'd0);

    // Mixed letters and a substituted space, held then drained
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h68, 1'b0, 1'b0); step();
    drive(1'b0, 8'h55, 1'b1, 1'b0); step();
    drive(1'b1, 8'h69, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mix_fill", {27'd0, fill}, 32'd3);
    chk("mix_b0", {24'd0, bus.out_data}, 32'h68);
    step();
    chk("mix_hold", {24'd0, bus.out_data}, 32'h68);
    bus.out_ready = 1'b1;
    step();
    chk("mix_b1", {24'd0, bus.out_data}, 32'h20);
    step();
    chk("mix_b2", {24'd0, bus.out_data}, 32'h69);
    step();
    chk("mix_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("mix_subst", {16'd0, subst_cnt}, 32'd1);
    chk("mix_letter", {16'd0, letter_cnt}, 32'd28);

    // Key error wins over ctx_ready
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h41, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("key_cnt", {16'd0, keyerr_cnt}, 32'd5);
    chk("key_fill", {27'd0, fill}, 32'd0);
    chk("key_letter", {16'd0, letter_cnt}, 32'd28);
    chk("key_state", 32'(dut.state_q), 32'(StIdle));

    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_key", {16'd0, keyerr_cnt}, 32'd0);
    chk("clr_letter", {16'd0, letter_cnt}, 32'd0);

    // Overflow: 17 pushes into 16 entries with no drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
      step();
      if (i == 15) begin
        chk("ovf_full_fill", {27'd0, fill}, 32'd16);
        chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_fill", {27'd0, fill}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_letter", {16'd0, letter_cnt}, 32'd16);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", {24'd0, bus.out_data}, 32'(8'h61 + i));
      step();
    end
    chk("ovf_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    chk("ovf_clr_state", 32'(dut.state_q), 32'(StIdle));

    // Full FIFO with simultaneous push and pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
      step();
    end
    chk("fpp_fill16", {27'd0, fill}, 32'd16);
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h51, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fpp_fill", {27'd0, fill}, 32'd16);
    chk("fpp_ovf", {31'd0, overflow}, 32'd0);
    chk("fpp_letter", {16'd0, letter_cnt}, 32'd17);
    for (int i = 0; i < 16; i++) begin
      chk("fpp_order", {24'd0, bus.out_data}, 32'(8'h42 + i));
      step();
    end
    chk("fpp_empty", {27'd0, fill}, 32'd0);

    // Asynchronous reset with 7 bytes buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mrst_fill7", {27'd0, fill}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_data", {24'd0, bus.out_data}, 32'h00);
    chk("mrst_letter", {16'd0, letter_cnt}, 32'd0);
    chk("mrst_fill", {27'd0, fill}, 32'd0);
    chk("mrst_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h7A, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mrst_first", {24'd0, bus.out_data}, 32'h7A);
    chk("mrst_fill1", {27'd0, fill}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
